// File: rtl/button_debouncer.sv
// button_debouncer: per-bit synchroniser, bounce filter and edge detector.
// Each bit passes through a 2-flop synchroniser. A new level is accepted only
// after STABLE_CYCLES consecutive synchronised samples differ from the current
// debounced state. Each accepted edge emits a one-cycle pressed or released pulse.
// Optional feature macro: DEBOUNCE_REPEAT_EN adds auto-repeat pressed pulses
// while a button is held (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles).
module button_debouncer #(
    parameter int SIZE          = 1,
    parameter int STABLE_CYCLES = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] in,
    output logic [SIZE-1:0] state,
    output logic [SIZE-1:0] pressed,
    output logic [SIZE-1:0] released
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SIZE-1:0]         r_s1;
    logic [SIZE-1:0]         r_s2;
    logic [SIZE-1:0][CW-1:0] r_cnt;
    logic [SIZE-1:0]         w_accept;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_ONE         = RW'(1);

    // r_per marks that the first (delayed) repeat has already fired
    logic [SIZE-1:0][RW-1:0] r_rpt;
    logic [SIZE-1:0]         r_per;
    logic [SIZE-1:0][RW-1:0] w_rpt_last;
`else
    // Repeat timing is not used in this build; fold it into a deliberately unused net
    logic w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // Two-flop synchroniser on every raw input bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
        end
    end

    // Acceptance: synchronised level has differed for the full stability window
    always_comb begin
        w_accept = '0;
`ifdef DEBOUNCE_REPEAT_EN
        w_rpt_last = '0;
`endif
        for (int i = 0; i < SIZE; i++) begin
            w_accept[i] = (r_s2[i] != state[i]) && (r_cnt[i] == CNT_LAST);
`ifdef DEBOUNCE_REPEAT_EN
            w_rpt_last[i] = r_per[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
`endif
        end
    end

    // Stability counters, debounced state and one-cycle edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            state    <= '0;
            pressed  <= '0;
            released <= '0;
`ifdef DEBOUNCE_REPEAT_EN
            r_rpt    <= '0;
            r_per    <= '0;
`endif
        end else begin
            pressed  <= '0;
            released <= '0;
            for (int i = 0; i < SIZE; i++) begin
                if (w_accept[i]) begin
                    state[i]    <= r_s2[i];
                    r_cnt[i]    <= '0;
                    pressed[i]  <= r_s2[i];
                    released[i] <= ~r_s2[i];
`ifdef DEBOUNCE_REPEAT_EN
                    // A press restarts repeat timing; a release cancels it
                    r_rpt[i]    <= '0;
                    r_per[i]    <= 1'b0;
`endif
                end else begin
                    // Any sample matching the current state discards progress
                    if (r_s2[i] == state[i]) begin
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
`ifdef DEBOUNCE_REPEAT_EN
                    if (!state[i]) begin
                        r_rpt[i] <= '0;
                        r_per[i] <= 1'b0;
                    end else if (r_rpt[i] == w_rpt_last[i]) begin
                        pressed[i] <= 1'b1;
                        r_rpt[i]   <= '0;
                        r_per[i]   <= 1'b1;
                    end else begin
                        r_rpt[i] <= r_rpt[i] + RPT_ONE;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer (SIZE=2, STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). The reference model keeps the full history of sampled
// inputs and accepts a new level when the last STABLE_CYCLES synchronised
// samples all differ from the debounced state. Repeat pulses are computed
// from the distance to the press edge when DEBOUNCE_REPEAT_EN is defined.
module tb_button_debouncer;

    localparam int SIZE = 2;
    localparam int SC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] in = '0;
    logic [SIZE-1:0] state;
    logic [SIZE-1:0] pressed;
    logic [SIZE-1:0] released;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [SIZE-1:0] hist[$];
    logic [SIZE-1:0] m_state    = '0;
    logic [SIZE-1:0] m_pressed  = '0;
    logic [SIZE-1:0] m_released = '0;
    int              m_t = 0;
    int              m_p[SIZE];

    button_debouncer #(
        .SIZE(SIZE), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .in(in),
        .state(state), .pressed(pressed), .released(released)
    );

    always #5 clk = ~clk;

    task automatic apply_reset(int cycles);
        rst = 1'b1;
        m_state = '0; m_pressed = '0; m_released = '0;
        hist.delete();
        m_t = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock edge: update the model from history, then settle past the edge
    task automatic step();
        logic [SIZE-1:0] nxt_s, nxt_p, nxt_r;
        @(posedge clk);
        nxt_s = m_state; nxt_p = '0; nxt_r = '0;
        for (int i = 0; i < SIZE; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 2; k <= SC + 1; k++) begin
                int   idx;
                logic v;
                idx = m_t - k;
                v = (idx >= 0) ? hist[idx][i] : 1'b0;
                if (v == m_state[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                nxt_s[i] = ~m_state[i];
                if (nxt_s[i]) begin
                    nxt_p[i] = 1'b1;
                    m_p[i] = m_t;
                end else begin
                    nxt_r[i] = 1'b1;
                end
            end
`ifdef DEBOUNCE_REPEAT_EN
            else if (m_state[i]) begin
                int d;
                d = m_t - m_p[i];
                if (d == RD || (d > RD && (d - RD) % RP == 0)) nxt_p[i] = 1'b1;
            end
`endif
        end
        hist.push_back(in);
        m_t++;
        m_state = nxt_s; m_pressed = nxt_p; m_released = nxt_r;
        #1;
    endtask

    task automatic test_reset();
        int pe, cnt;
        in = 2'b11;
        rst = 1'b1;
        m_state = '0; m_pressed = '0; m_released = '0; hist.delete(); m_t = 0;
        repeat (10) begin
            @(posedge clk); #1;
            n_tests++;
            if ({state, pressed, released} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold got s=%b p=%b r=%b exp all 0", state, pressed, released);
            end
        end
        rst = 1'b0;
        pe = -1; cnt = 0;
        repeat (9) begin
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL reset_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (pressed != 0) begin pe = m_t - 1; cnt++; end
        end
        n_tests++;
        if (pe !== 5 || cnt !== 1 || state !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_press got edge=%0d count=%0d state=%b exp edge=5 count=1 state=11",
                     pe, cnt, state);
        end
    endtask

    task automatic test_press_release();
        int n0, pe, re;
        in = '0;
        apply_reset(3);
        in = 2'b01;
        n0 = m_t; pe = -1; re = -1;
        repeat (10) begin
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL press_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (pressed[0]) pe = m_t - 1;
        end
        n_tests++;
        if (pe !== n0 + 5 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL press_latency got edge=%0d state=%b exp edge=%0d state=01", pe, state, n0 + 5);
        end
        in = 2'b00;
        n0 = m_t;
        repeat (10) begin
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL release_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (released[0]) re = m_t - 1;
        end
        n_tests++;
        if (re !== n0 + 5 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL release_latency got edge=%0d state=%b exp edge=%0d state=00", re, state, n0 + 5);
        end
    endtask

    task automatic test_bounce();
        int n0, pe, cnt;
        in = '0;
        apply_reset(2);
        n0 = m_t; pe = -1; cnt = 0;
        for (int c = 0; c < 24; c++) begin
            in = (c >= 12 || (c % 4) < 2) ? 2'b01 : 2'b00;
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL bounce_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (pressed != 0 || released != 0) begin pe = m_t - 1; cnt++; end
        end
        n_tests++;
        if (cnt !== 1 || pe !== n0 + 12 + 5) begin
            n_fail++;
            $display("FAIL bounce_single_pulse got count=%0d edge=%0d exp count=1 edge=%0d", cnt, pe, n0 + 17);
        end
    endtask

    task automatic test_glitch();
        int ev;
        in = '0;
        apply_reset(2);
        ev = 0;
        for (int c = 0; c < 14; c++) begin
            in = (c < 3) ? 2'b11 : 2'b00;
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL glitch_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if ({state, pressed, released} != 0) ev++;
        end
        n_tests++;
        if (ev !== 0) begin
            n_fail++;
            $display("FAIL glitch_reject got nonzero_cycles=%0d exp 0", ev);
        end
    endtask

    task automatic test_multibit();
        logic [SIZE-1:0] pv, rv, sv;
        in = '0;
        apply_reset(2);
        in = 2'b11;
        pv = '0;
        repeat (8) begin
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL multi_press_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (pressed != 0) pv = pressed;
        end
        n_tests++;
        if (pv !== 2'b11) begin
            n_fail++;
            $display("FAIL multi_press_same_cycle got pressed=%b exp 11", pv);
        end
        in = 2'b01;
        rv = '0; sv = '0;
        repeat (8) begin
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL multi_release_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (released != 0) begin rv = released; sv = state; end
        end
        n_tests++;
        if (rv !== 2'b10 || sv !== 2'b01) begin
            n_fail++;
            $display("FAIL multi_release_bit1 got released=%b state=%b exp released=10 state=01", rv, sv);
        end
    endtask

    task automatic test_repeat();
        logic [17:0] got, exp_v;
        int P;
        bit have_p;
        in = '0;
        apply_reset(2);
        got = '0; have_p = 1'b0; P = 0;
`ifdef DEBOUNCE_REPEAT_EN
        exp_v = 18'b0;
        exp_v[0] = 1'b1; exp_v[10] = 1'b1; exp_v[13] = 1'b1; exp_v[16] = 1'b1;
`else
        exp_v = 18'b1;
`endif
        for (int c = 0; c < 42; c++) begin
            in = (c < 26) ? 2'b01 : 2'b00;
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL repeat_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
            if (pressed[0]) begin
                if (!have_p) begin P = m_t - 1; have_p = 1'b1; end
                if (m_t - 1 - P < 18) got[m_t - 1 - P] = 1'b1;
            end
        end
        n_tests++;
        if (got !== exp_v || state !== 2'b00) begin
            n_fail++;
            $display("FAIL repeat_pattern got offsets=%b state=%b exp offsets=%b state=00", got, state, exp_v);
        end
    endtask

    task automatic test_random();
        int hold[SIZE];
        for (int i = 0; i < SIZE; i++) hold[i] = 0;
        in = '0;
        apply_reset(2);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < SIZE; i++) begin
                if (hold[i] == 0) begin
                    in[i] = $urandom_range(0, 1);
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : $urandom_range(1, 5);
                end
                hold[i]--;
            end
            if (c == 300) apply_reset(2);
            step();
            n_tests++;
            if ({state, pressed, released} !== {m_state, m_pressed, m_released}) begin
                n_fail++;
                $display("FAIL random_model t=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b",
                         m_t - 1, state, pressed, released, m_state, m_pressed, m_released);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_multibit();
        test_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
